// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the program counter and keeps at
// most one request outstanding to instruction memory. Each cycle it offers
// if_pc_4 / if_instruction / if_valid to the IF/ID register downstream, and
// absorbs memory wait states, ID stalls and ID redirects by emitting NOPs and
// buffering a single fetched word.
//
// Ports
//   clock, reset          posedge clock, synchronous active-high reset
//   id_shouldStall        IF/ID holds this cycle; nothing may be delivered
//   id_redirect           taken branch/jump in ID (ignored while stalled)
//   id_redirect_pc        redirect target, low two bits forced to zero
//   imem_req / imem_addr  request valid and word address (always pc)
//   imem_ready/imem_rdata returned word; ready completes the request
//   if_pc_4               pc + 4
//   if_instruction        word offered to IF/ID (NOP when not valid)
//   if_valid              if_instruction is a real, non-squashed instruction
//
// state | meaning
// FETCH | request outstanding at pc; ready delivers, buffers or squashes
// DRAIN | redirect arrived mid-request; wait out the old request, then jump
// HOLD  | word fetched during a stall; present buffer until ID accepts it
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_shouldStall,
    input  logic        id_redirect,
    input  logic [31:0] id_redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc_4,
    output logic [31:0] if_instruction,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] buf_instr, buf_instr_nxt;
    logic [31:0] pend_pc, pend_pc_nxt;
    logic        redir;
    logic [31:0] target;

    assign redir  = id_redirect & ~id_shouldStall;
    assign target = {id_redirect_pc[31:2], 2'b00};

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            buf_instr <= NOP;
            pend_pc   <= RESET_PC;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            buf_instr <= buf_instr_nxt;
            pend_pc   <= pend_pc_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        buf_instr_nxt  = buf_instr;
        pend_pc_nxt    = pend_pc;
        if_instruction = NOP;
        if_valid       = 1'b0;
        // Dropped combinationally on reset so a request in flight is abandoned.
        imem_req       = ~reset & (state != HOLD);

        case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (redir) begin
                        pc_nxt = target;
                    end else if (id_shouldStall) begin
                        buf_instr_nxt = imem_rdata;
                        state_nxt     = HOLD;
                    end else begin
                        if_instruction = imem_rdata;
                        if_valid       = 1'b1;
                        pc_nxt         = pc + 32'd4;
                    end
                end else if (redir) begin
                    pend_pc_nxt = target;
                    state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                // pc stays put so the address is stable until ready. A
                // redirect landing on the ready cycle is the newest and wins.
                if (redir) begin
                    pend_pc_nxt = target;
                end
                if (imem_ready) begin
                    pc_nxt    = redir ? target : pend_pc;
                    state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_nxt    = target;
                    state_nxt = FETCH;
                end else begin
                    if_instruction = buf_instr;
                    if_valid       = 1'b1;
                    if (!id_shouldStall) begin
                        pc_nxt    = pc + 32'd4;
                        state_nxt = FETCH;
                    end
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase

        if (reset) begin
            if_instruction = NOP;
            if_valid       = 1'b0;
        end
    end

    assign imem_addr = pc;
    assign if_pc_4   = pc + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        id_shouldStall;
    logic        id_redirect;
    logic [31:0] id_redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc_4;
    logic [31:0] if_instruction;
    logic        if_valid;

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .id_shouldStall (id_shouldStall),
        .id_redirect    (id_redirect),
        .id_redirect_pc (id_redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_pc_4        (if_pc_4),
        .if_instruction (if_instruction),
        .if_valid       (if_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then move off it before driving/checking.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Set inputs for the current cycle and let combinational outputs settle.
    task automatic drive(input logic rdy, input logic [31:0] rdata, input logic stall,
                         input logic redir, input logic [31:0] tgt);
        imem_ready     = rdy;
        imem_rdata     = rdata;
        id_shouldStall = stall;
        id_redirect    = redir;
        id_redirect_pc = tgt;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();

        // Reset state
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_instr", if_instruction, 32'h0);
        chk("rst_pc4", if_pc_4, 32'd4);

        // Zero-wait memory, one instruction per cycle
        reset = 1'b0;
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        chk("zw0_req", {31'b0, imem_req}, 32'd1);
        chk("zw0_addr", imem_addr, 32'h0);
        chk("zw0_valid", {31'b0, if_valid}, 32'd1);
        chk("zw0_instr", if_instruction, 32'h100);
        chk("zw0_pc4", if_pc_4, 32'd4);
        tick();
        drive(1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
        chk("zw1_addr", imem_addr, 32'h4);
        chk("zw1_instr", if_instruction, 32'h104);
        chk("zw1_pc4", if_pc_4, 32'd8);
        tick();
        drive(1'b1, 32'h108, 1'b0, 1'b0, 32'h0);
        chk("zw2_addr", imem_addr, 32'h8);
        chk("zw2_valid", {31'b0, if_valid}, 32'd1);
        chk("zw2_pc4", if_pc_4, 32'd12);
        tick();

        // Two-wait memory at pc=0xC
        drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        chk("w2a_addr", imem_addr, 32'hC);
        chk("w2a_valid", {31'b0, if_valid}, 32'd0);
        chk("w2a_instr", if_instruction, 32'h0);
        tick();
        drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        chk("w2b_addr", imem_addr, 32'hC);
        chk("w2b_valid", {31'b0, if_valid}, 32'd0);
        tick();
        drive(1'b1, 32'h10C, 1'b0, 1'b0, 32'h0);
        chk("w2c_addr", imem_addr, 32'hC);
        chk("w2c_valid", {31'b0, if_valid}, 32'd1);
        chk("w2c_instr", if_instruction, 32'h10C);
        tick();

        // Ready while stalled -> HOLD for three stalled cycles at pc=0x10
        drive(1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 32'h0);
        chk("st0_addr", imem_addr, 32'h10);
        chk("st0_valid", {31'b0, if_valid}, 32'd0);
        chk("st0_instr", if_instruction, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("hold1_req", {31'b0, imem_req}, 32'd0);
        chk("hold1_instr", if_instruction, 32'hAAAA_0001);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("hold2_req", {31'b0, imem_req}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("hold_dlv_valid", {31'b0, if_valid}, 32'd1);
        chk("hold_dlv_instr", if_instruction, 32'hAAAA_0001);
        chk("hold_dlv_req", {31'b0, imem_req}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("post_hold_addr", imem_addr, 32'h14);
        chk("post_hold_req", {31'b0, imem_req}, 32'd1);
        chk("post_hold_valid", {31'b0, if_valid}, 32'd0);

        // Redirect in the same cycle as ready -> squash, next addr = target
        drive(1'b1, 32'hBBBB_0000, 1'b0, 1'b1, 32'h10);
        chk("rr_valid", {31'b0, if_valid}, 32'd0);
        chk("rr_instr", if_instruction, 32'h0);
        tick();
        // Redirect to 0x400 while 3-wait request to 0x10 outstanding -> DRAIN
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h400);
        chk("dr0_addr", imem_addr, 32'h10);
        chk("dr0_valid", {31'b0, if_valid}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("dr1_addr", imem_addr, 32'h10);
        chk("dr1_req", {31'b0, imem_req}, 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("dr2_addr", imem_addr, 32'h10);
        tick();
        drive(1'b1, 32'hCCCC_0000, 1'b0, 1'b0, 32'h0);
        chk("dr3_addr", imem_addr, 32'h10);
        chk("dr3_valid", {31'b0, if_valid}, 32'd0);
        chk("dr3_instr", if_instruction, 32'h0);
        tick();
        drive(1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
        chk("tgt_addr", imem_addr, 32'h400);
        chk("tgt_valid", {31'b0, if_valid}, 32'd1);
        chk("tgt_instr", if_instruction, 32'h500);
        tick();

        // Redirect together with stall is ignored (pc=0x404)
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h800);
        chk("rs_valid", {31'b0, if_valid}, 32'd0);
        tick();
        drive(1'b1, 32'h504, 1'b0, 1'b0, 32'h0);
        chk("rs_addr", imem_addr, 32'h404);
        chk("rs_valid2", {31'b0, if_valid}, 32'd1);
        chk("rs_instr", if_instruction, 32'h504);
        tick();

        // Wrap at 0xFFFF_FFFC; low target bits are forced to zero
        drive(1'b1, 32'h508, 1'b0, 1'b1, 32'hFFFF_FFFE);
        chk("wr_sq_valid", {31'b0, if_valid}, 32'd0);
        tick();
        drive(1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 32'h0);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wr_pc4", if_pc_4, 32'h0);
        chk("wr_valid", {31'b0, if_valid}, 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wr_next_addr", imem_addr, 32'h0);

        // Reset during DRAIN
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        chk("rd_req", {31'b0, imem_req}, 32'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        chk("rd_addr", imem_addr, 32'h0);
        chk("rd_req2", {31'b0, imem_req}, 32'd1);
        chk("rd_valid", {31'b0, if_valid}, 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline. It owns the program counter and runs a single-outstanding request/ready handshake to instruction memory. Each cycle it presents `if_pc_4` and `if_instruction` to the IF/ID pipeline register directly downstream. It absorbs variable memory latency, ID-stage stalls and branch/jump redirects by inserting NOPs (32'h0000_0000) and buffering one fetched word.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `NOP`, 32'h0000_0000, word driven on `if_instruction` when no valid instruction is presented.
- `clock` in 1: all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `id_shouldStall` in 1: IF/ID holds this cycle; fetch must not deliver.
- `id_redirect` in 1: branch/jump taken in ID; honoured only when `id_shouldStall`=0.
- `id_redirect_pc` in 32: redirect target; bits [1:0] forced to 0.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: word address, equal to `pc`.
- `imem_ready` in 1: `imem_rdata` valid this cycle; ends the request.
- `imem_rdata` in 32: fetched word.
- `if_pc_4` out 32: `pc`+4, modulo 2^32.
- `if_instruction` out 32: instruction offered to IF/ID.
- `if_valid` out 1: `if_instruction` is a real, non-squashed instruction.

## Operation
- Registers: `pc`, `state` {FETCH, DRAIN, HOLD}, `buf_instr`, `pend_pc`.
- Definitions:
  - `redir` = `id_redirect` & ~`id_shouldStall`.
  - "deliver" means `if_valid`=1 and IF/ID captures the instruction at the edge.
- **FETCH**: `imem_req`=1, `imem_addr`=`pc`.
  - `imem_ready` & `redir`: word squashed, output NOP, `pc`<=target, stay FETCH.
  - `imem_ready` & `id_shouldStall`: `buf_instr`<=`imem_rdata`, go to HOLD, `pc` unchanged.
  - `imem_ready` otherwise: deliver `imem_rdata`, `pc`<=`pc`+4, stay FETCH.
  - No `imem_ready` & `redir`: `pend_pc`<=target, go to DRAIN.
  - No `imem_ready` otherwise: hold `pc`, output NOP.
- **DRAIN**: `imem_req`=1, `imem_addr`=old `pc` (held stable), output NOP.
  - On `imem_ready`: data discarded, `pc`<=`pend_pc`, go to FETCH.
  - Another `redir` while in DRAIN overwrites `pend_pc`.
- **HOLD**: `imem_req`=0, `if_instruction`=`buf_instr`.
  - `if_valid`=1 except when the `redir` squash below applies.
  - `id_shouldStall`: stay in HOLD.
  - `redir`: output NOP, drop buffer, `pc`<=target, go to FETCH.
  - Otherwise: deliver, `pc`<=`pc`+4, go to FETCH.
- `if_instruction`=`NOP` and `if_valid`=0 whenever not delivering.
  - This includes the cycle of a `redir` squash.
  - This also includes every stall cycle in FETCH and DRAIN.
- `if_pc_4`=`pc`+4 at all times; `pc` 32'hFFFF_FFFC wraps so `if_pc_4`=0.
- Memory protocol:
  - `imem_addr` must not change while `imem_req`=1 and `imem_ready` has not been seen.
  - Address may change in the cycle after `imem_ready`.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `state`=FETCH.
  - `imem_req`=0 while `reset`=1.
  - `if_instruction`=`NOP`, `if_valid`=0, `if_pc_4`=`RESET_PC`+4.
- First request is asserted in the first cycle with `reset`=0.
- Output paths:
  - `imem_rdata` to `if_instruction` is combinational in FETCH.
  - IF/ID captures at the same edge `imem_ready` is high: zero-cycle fetch latency.
- Zero-wait memory (`imem_ready`=1 every cycle) sustains one instruction per cycle with `imem_req` held high.
- N-wait memory gives N NOP cycles per instruction.
- After a redirect, the first target instruction is delivered:
  - no earlier than 1 cycle later from FETCH or HOLD;
  - no earlier than 1 cycle after the drained `imem_ready` from DRAIN.
- Simultaneous `id_redirect` and `id_shouldStall`: redirect ignored; ID re-asserts it when unstalled.
- `reset` mid-request: the outstanding request is abandoned.
  - `imem_req` drops the same cycle (combinational on `reset`).
  - All registers reinitialise at the edge.
  - Memory is reset by the same signal.

## Test plan
- Reset with `RESET_PC`=0 and zero-wait memory returning addr|0x100 -> `imem_addr` 0,4,8 on consecutive cycles; `if_valid`=1 each cycle; `if_pc_4`=4,8,12.
- 2-wait memory -> each word is preceded by 2 cycles of `if_valid`=0 and `if_instruction`=0; `imem_addr` stable across the wait cycles.
- `imem_ready` arrives while `id_shouldStall`=1 for 3 cycles -> HOLD.
  - `imem_req`=0 during HOLD and `buf_instr` is presented.
  - The word is delivered exactly once, on the first unstalled cycle.
  - The next request goes to `pc`+4.
- `redir` to 0x400 while a 3-wait request to 0x10 is outstanding -> DRAIN.
  - `imem_addr` stays 0x10 until ready; that word is discarded (`if_valid`=0).
  - Next `imem_addr`=0x400.
- Corner cases:
  - `redir` in the same cycle as `imem_ready` -> NOP output and next address equals the target.
  - `id_redirect` together with `id_shouldStall` -> ignored.
  - `pc`=0xFFFF_FFFC -> `if_pc_4`=0 and next fetch at 0.
  - `reset` during DRAIN -> `imem_req`=0 that cycle and fetch restarts at `RESET_PC`.
